multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing the multi-cycle MIPS datapath: PC, IR, register file, ALU, data memory.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_alu_dec.sv | 33 +++
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// datapath select codes and FSM state codes.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      RS_ALU = 2'd0,
      RS_MEM = 2'd1,
      RS_LUI = 2'd2
   } reg_src_e;

   typedef enum logic [1:0] {
      SRCB_RT   = 2'd0,
      SRCB_SEXT = 2'd1,
      SRCB_ZEXT = 2'd2
   } src_b_e;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC   = 4'd2,
      ST_WB_ALU = 4'd3,
      ST_ADDR   = 4'd4,
      ST_MEM_RD = 4'd5,
      ST_MEM_WR = 4'd6,
      ST_WB_MEM = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9,
      ST_ERR    = 4'd10
   } state_e;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// Instruction decode: maps (opcode, funct) to the ALU operation and flags
// anything outside the supported subset as invalid.
module multicycle_ctrl_alu_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       valid
);

   always_comb begin
      alu_op = ALU_ADD;
      valid  = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: alu_op = ALU_ADD;
               FN_SUBU: alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: valid  = 1'b0;
            endcase
         end
         OP_ORI:  alu_op = ALU_OR;
         OP_BEQ:  alu_op = ALU_SUB;
         OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_J: alu_op = ALU_ADD;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath, with a bounded wait on
// the data-memory handshake and retired-instruction / cycle counters.
//
// state     | meaning
// FETCH     | load IR, PC <= PC+4
// DECODE    | opcode/funct classified, no writes
// EXEC      | ALU op for R / addiu / ori
// WB_ALU    | write ALU or lui result, retire
// ADDR      | effective address for lw / sw
// MEM_RD    | read request until mem_ready
// MEM_WR    | write request until mem_ready, retire on ready
// WB_MEM    | write load data, retire
// BRANCH    | compare, PC <= target when zero, retire
// JUMP      | PC <= jump target, retire
// ERR       | illegal instruction or memory timeout, sticky until rst
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int MEM_TMO = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             ir_we,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             rf_we,
   output logic             reg_dst,
   output logic [1:0]       reg_src,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic [3:0]       state_o,
   output logic             instr_done,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int TMO_W = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TMO);

   state_e           state;
   logic [TMO_W-1:0] wait_cnt;
   logic [2:0]       dec_alu_op;
   logic             dec_valid;
   logic             retire;

   multicycle_ctrl_alu_dec u_alu_dec (
      .opcode (opcode),
      .funct  (funct),
      .alu_op (dec_alu_op),
      .valid  (dec_valid)
   );

   // A store completes in MEM_WR itself, so its retire is the one place the
   // handshake reaches the retire pulse.
   assign retire = (state == ST_WB_ALU) || (state == ST_WB_MEM) ||
                   (state == ST_BRANCH) || (state == ST_JUMP) ||
                   ((state == ST_MEM_WR) && mem_ready);

   assign state_o = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FETCH;
         wait_cnt  <= '0;
         instr_cnt <= '0;
         cycle_cnt <= '0;
      end else begin
         if (state != ST_ERR)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire)
            instr_cnt <= instr_cnt + CNT_W'(1);
         case (state)
            ST_FETCH:  state <= ST_DECODE;
            ST_DECODE: begin
               if (!dec_valid)
                  state <= ST_ERR;
               else begin
                  case (opcode)
                     OP_RTYPE, OP_ADDIU, OP_ORI: state <= ST_EXEC;
                     OP_LUI:                     state <= ST_WB_ALU;
                     OP_LW, OP_SW:               state <= ST_ADDR;
                     OP_BEQ:                     state <= ST_BRANCH;
                     OP_J:                       state <= ST_JUMP;
                     default:                    state <= ST_ERR;
                  endcase
               end
            end
            ST_EXEC: state <= ST_WB_ALU;
            ST_ADDR: begin
               wait_cnt <= TMO_LOAD;
               state    <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            // Down-counter covers MEM_TMO+1 unanswered cycles before giving up.
            ST_MEM_RD, ST_MEM_WR: begin
               if (mem_ready)
                  state <= (state == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
               else if (wait_cnt == '0)
                  state <= ST_ERR;
               else
                  wait_cnt <= wait_cnt - TMO_W'(1);
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state <= ST_FETCH;
            ST_ERR:  state <= ST_ERR;
            default: state <= ST_ERR;
         endcase
      end
   end

   always_comb begin
      pc_we      = 1'b0;
      pc_src     = PC_PLUS4;
      ir_we      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      rf_we      = 1'b0;
      reg_dst    = 1'b0;
      reg_src    = RS_ALU;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;
      halted     = 1'b0;
      if (!rst) begin
         case (state)
            ST_FETCH: begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end
            ST_EXEC: begin
               alu_op = dec_alu_op;
               case (opcode)
                  OP_ADDIU: alu_src_b = SRCB_SEXT;
                  OP_ORI:   alu_src_b = SRCB_ZEXT;
                  default:  alu_src_b = SRCB_RT;
               endcase
            end
            ST_WB_ALU: begin
               rf_we   = 1'b1;
               reg_dst = (opcode == OP_RTYPE);
               reg_src = (opcode == OP_LUI) ? RS_LUI : RS_ALU;
            end
            ST_ADDR: begin
               alu_op    = ALU_ADD;
               alu_src_b = SRCB_SEXT;
            end
            ST_MEM_RD: mem_rd = 1'b1;
            ST_MEM_WR: mem_wr = 1'b1;
            ST_WB_MEM: begin
               rf_we   = 1'b1;
               reg_src = RS_MEM;
            end
            ST_BRANCH: begin
               alu_op = ALU_SUB;
               pc_we  = zero;
               pc_src = PC_BRANCH;
            end
            ST_JUMP: begin
               pc_we  = 1'b1;
               pc_src = PC_JUMP;
            end
            ST_ERR:  halted = 1'b1;
            default: ;
         endcase
         instr_done = retire;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of single instructions run back to back,
// then hand sequences for illegal opcodes, memory timeout and mid-flight reset.
module tb_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'h00;
   logic [5:0]  funct = 6'h00;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_we, ir_we, mem_rd, mem_wr, rf_we, reg_dst, instr_done, halted;
   logic [1:0]  pc_src, reg_src, alu_src_b;
   logic [2:0]  alu_op;
   logic [3:0]  state_o;
   logic [31:0] instr_cnt, cycle_cnt;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_we(rf_we), .reg_dst(reg_dst),
      .reg_src(reg_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .state_o(state_o), .instr_done(instr_done), .halted(halted),
      .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         waits;
      int         lat;
      int         rf_n;
      int         mem_n;
      logic       rdst;
      logic [1:0] rsrc;
      logic [3:0] alu_st;
      logic [2:0] aop;
      logic [1:0] srcb;
      logic       pcwe;
      logic [1:0] pcsrc;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          tot_cyc;
   int          wait_seen;
   int          waits_cur;
   int          exp_icnt;
   logic        pend;
   logic [31:0] pend_val;
   logic [31:0] sb_q[$];
   vec_t        vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One cycle: sample at negedge, drive mem_ready from the wait budget, then compare.
   task automatic step();
      @(negedge clk);
      if (state_o == ST_MEM_RD || state_o == ST_MEM_WR) begin
         mem_ready = (wait_seen >= waits_cur);
         wait_seen++;
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      tot_cyc++;
      if (pend) begin
         chk("instr_cnt", instr_cnt, pend_val);
         pend = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", 32'({ir_we, pc_we, mem_rd, mem_wr, rf_we, instr_done, halted,
                           reg_dst, pc_src, reg_src, alu_src_b, alu_op}), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_cnt", instr_cnt | cycle_cnt, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tot_cyc = -1;
      exp_icnt = 0;
      pend = 1'b0;
      sb_q.delete();
   endtask

   function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int w, input int lat, input int rfn,
                               input int memn, input logic rdst, input logic [1:0] rsrc,
                               input logic [3:0] ast, input logic [2:0] aop,
                               input logic [1:0] srcb, input logic pcwe,
                               input logic [1:0] pcsrc);
      vec_t v;
      v.name = nm; v.op = op; v.fn = fn; v.z = z; v.waits = w; v.lat = lat;
      v.rf_n = rfn; v.mem_n = memn; v.rdst = rdst; v.rsrc = rsrc; v.alu_st = ast;
      v.aop = aop; v.srcb = srcb; v.pcwe = pcwe; v.pcsrc = pcsrc;
      return v;
   endfunction

   task automatic run_instr(input vec_t v);
      int   lat, rf_n, ir_n, mem_n;
      logic done;
      opcode = v.op; funct = v.fn; zero = v.z;
      waits_cur = v.waits; wait_seen = 0;
      exp_icnt++;
      sb_q.push_back(32'(exp_icnt));
      lat = 0; rf_n = 0; ir_n = 0; mem_n = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         step();
         lat++;
         if (c == 0)
            chk({v.name, ":fetch"}, 32'({state_o, ir_we, pc_we, pc_src, halted}),
                32'({4'd0, 1'b1, 1'b1, 2'd0, 1'b0}));
         if (ir_we) ir_n++;
         if (mem_rd || mem_wr) mem_n++;
         if (rf_we) begin
            rf_n++;
            chk({v.name, ":wb_sel"}, 32'({reg_dst, reg_src}), 32'({v.rdst, v.rsrc}));
         end
         if (state_o == v.alu_st)
            chk({v.name, ":alu"}, 32'({alu_op, alu_src_b}), 32'({v.aop, v.srcb}));
         if (instr_done) begin
            done = 1'b1;
            chk({v.name, ":pc"}, 32'({pc_we, pc_src}), 32'({v.pcwe, v.pcsrc}));
            chk({v.name, ":cycle_cnt"}, cycle_cnt, 32'(tot_cyc));
            pend_val = sb_q.pop_front();
            pend = 1'b1;
         end
      end
      chk({v.name, ":retired"}, 32'(done), 32'd1);
      chk({v.name, ":latency"}, 32'(lat), 32'(v.lat));
      chk({v.name, ":rf_we_n"}, 32'(rf_n), 32'(v.rf_n));
      chk({v.name, ":ir_we_n"}, 32'(ir_n), 32'd1);
      chk({v.name, ":mem_n"}, 32'(mem_n), 32'(v.mem_n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] cc;
      //             name     op     fn     z  w  lat rf mem rdst rsrc alu_state  aop srcb pcwe pcsrc
      vecs[0]  = mk("addu",  6'h00, 6'h21, 0, 0, 4, 1, 0, 1, 2'd0, ST_EXEC,   3'd0, 2'd0, 0, 2'd0);
      vecs[1]  = mk("subu",  6'h00, 6'h23, 0, 0, 4, 1, 0, 1, 2'd0, ST_EXEC,   3'd1, 2'd0, 0, 2'd0);
      vecs[2]  = mk("and",   6'h00, 6'h24, 0, 0, 4, 1, 0, 1, 2'd0, ST_EXEC,   3'd2, 2'd0, 0, 2'd0);
      vecs[3]  = mk("or",    6'h00, 6'h25, 0, 0, 4, 1, 0, 1, 2'd0, ST_EXEC,   3'd3, 2'd0, 0, 2'd0);
      vecs[4]  = mk("slt",   6'h00, 6'h2A, 0, 0, 4, 1, 0, 1, 2'd0, ST_EXEC,   3'd4, 2'd0, 0, 2'd0);
      vecs[5]  = mk("addiu", 6'h09, 6'h00, 0, 0, 4, 1, 0, 0, 2'd0, ST_EXEC,   3'd0, 2'd1, 0, 2'd0);
      vecs[6]  = mk("ori",   6'h0D, 6'h00, 0, 0, 4, 1, 0, 0, 2'd0, ST_EXEC,   3'd3, 2'd2, 0, 2'd0);
      vecs[7]  = mk("lui",   6'h0F, 6'h00, 0, 0, 3, 1, 0, 0, 2'd2, 4'hF,      3'd0, 2'd0, 0, 2'd0);
      vecs[8]  = mk("lw0",   6'h23, 6'h00, 0, 0, 5, 1, 1, 0, 2'd1, ST_ADDR,   3'd0, 2'd1, 0, 2'd0);
      vecs[9]  = mk("lw3",   6'h23, 6'h00, 0, 3, 8, 1, 4, 0, 2'd1, ST_ADDR,   3'd0, 2'd1, 0, 2'd0);
      vecs[10] = mk("sw0",   6'h2B, 6'h00, 0, 0, 4, 0, 1, 0, 2'd0, ST_ADDR,   3'd0, 2'd1, 0, 2'd0);
      vecs[11] = mk("sw2",   6'h2B, 6'h00, 0, 2, 6, 0, 3, 0, 2'd0, ST_ADDR,   3'd0, 2'd1, 0, 2'd0);
      vecs[12] = mk("beq_t", 6'h04, 6'h00, 1, 0, 3, 0, 0, 0, 2'd0, ST_BRANCH, 3'd1, 2'd0, 1, 2'd1);
      vecs[13] = mk("beq_n", 6'h04, 6'h00, 0, 0, 3, 0, 0, 0, 2'd0, ST_BRANCH, 3'd1, 2'd0, 0, 2'd1);
      vecs[14] = mk("j",     6'h02, 6'h00, 0, 0, 3, 0, 0, 0, 2'd0, 4'hF,      3'd0, 2'd0, 1, 2'd2);

      do_reset();
      foreach (vecs[i]) run_instr(vecs[i]);
      step();

      // Illegal opcode after one retired instruction: ERR, counters frozen.
      do_reset();
      run_instr(vecs[0]);
      opcode = 6'h3F; funct = 6'h00;
      step();
      step();
      chk("ill:decode", 32'(state_o), 32'(ST_DECODE));
      step();
      chk("ill:err", 32'({state_o, halted}), 32'({4'(ST_ERR), 1'b1}));
      chk("ill:cycle_cnt", cycle_cnt, 32'd6);
      repeat (3) step();
      chk("ill:frozen", {cycle_cnt[15:0], instr_cnt[15:0]}, {16'd6, 16'd1});
      chk("ill:no_en", 32'({ir_we, pc_we, rf_we, mem_rd, mem_wr, instr_done}), 32'd0);

      do_reset();
      step();
      chk("post_rst", 32'({state_o, ir_we, halted}), 32'({4'd0, 1'b1, 1'b0}));
      chk("post_rst_cnt", instr_cnt | cycle_cnt, 32'd0);

      // Unsupported R-type funct also ends in ERR.
      do_reset();
      opcode = 6'h00; funct = 6'h20;
      repeat (3) step();
      chk("ill_fn:err", 32'({state_o, halted}), 32'({4'(ST_ERR), 1'b1}));

      // Store with no memory response times out after MEM_TMO+1 wait cycles.
      do_reset();
      opcode = 6'h2B; funct = 6'h00; waits_cur = 1000; wait_seen = 0;
      n = 0;
      for (int c = 0; c < 40 && state_o != ST_ERR; c++) begin
         step();
         if (mem_wr) n++;
      end
      chk("tmo:mem_wr_n", 32'(n), 32'd16);
      chk("tmo:err", 32'({state_o, halted, mem_wr}), 32'({4'(ST_ERR), 1'b1, 1'b0}));
      cc = cycle_cnt;
      step();
      chk("tmo:frozen", cycle_cnt, cc);

      // Reset while a load waits in MEM_RD aborts it without a write-back.
      do_reset();
      opcode = 6'h23; funct = 6'h00; waits_cur = 1000; wait_seen = 0;
      repeat (4) step();
      chk("abort:in_mem", 32'({state_o, mem_rd}), 32'({4'(ST_MEM_RD), 1'b1}));
      rst = 1'b1;
      step();
      chk("abort:state", 32'({state_o, mem_rd, rf_we, instr_done}), 32'd0);
      chk("abort:cnt", instr_cnt, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("abort:refetch", 32'({state_o, ir_we, rf_we}), 32'({4'd0, 1'b1, 1'b0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
